// File: rtl/fdown_pkg.sv
// Shared constants, reset tables, state encoding and bus helpers for the falling-ball game state.
package fdown_pkg;

    localparam int COORD_W    = 10;
    localparam int NUM_FLOORS = 3;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int MIN_GAP_W  = 40;

    typedef logic [COORD_W-1:0]                  coord_t;
    typedef logic [COORD_W:0]                    wide_t;
    typedef coord_t [NUM_FLOORS-1:0]             coordVec_t;
    typedef logic [NUM_FLOORS*COORD_W-1:0]       coordBus_t;

    typedef enum logic [2:0] {IDLE, PLAY, FLOORS, BALL_X, BALL_Y, OVER} state_t;

    // Element 0 is the least significant field of each bus.
    localparam coordVec_t FLOORS_RST = {10'd100, 10'd250, 10'd400};
    localparam coordVec_t GAPS_RST   = {10'd200, 10'd300, 10'd150};
    localparam coordVec_t WIDTHS_RST = {10'd40,  10'd35,  10'd60};
    localparam coord_t    X_RST      = 10'd320;
    localparam coord_t    Y_RST      = 10'd240;

    function automatic coordBus_t packBus(input coordVec_t v);
        return coordBus_t'(v);
    endfunction

    function automatic coordVec_t unpackBus(input coordBus_t b);
        return coordVec_t'(b);
    endfunction

endpackage

// File: rtl/fdown_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
// Latency: new value each cycle after reset releases.
// Backpressure: none; never stalls.
module fdown_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

endmodule

// File: rtl/fdown_physics.sv
// Per-frame game-state update: floor scroll/recycle, ball x move, ball y fall/land, game over.
// Latency: outputs final 3 cycles after an accepted frame_tick; busy high for exactly those cycles.
// Backpressure: frame_tick arriving while busy, idle or over is dropped, never queued.
module fdown_physics #(
    parameter int          BALL_R    = 8,
    parameter int          GRAVITY   = 4,
    parameter int          SCROLL    = 1,
    parameter int          XSPEED    = 3,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [29:0] floors_y,
    output logic [29:0] gaps_pos,
    output logic [29:0] gaps_width,
    output logic        game_over,
    output logic        busy
);
    import fdown_pkg::*;

    localparam wide_t R_W      = wide_t'(BALL_R);
    localparam wide_t GRAV_W   = wide_t'(GRAVITY);
    localparam wide_t SCROLL_W = wide_t'(SCROLL);
    localparam wide_t XS_W     = wide_t'(XSPEED);
    localparam wide_t X_MAX    = wide_t'(SCREEN_W - 1 - BALL_R);
    localparam wide_t Y_MAX    = wide_t'(SCREEN_H - 1 - BALL_R);

    state_t    state, stateNxt;
    coord_t    xPos, yPos, xNext, yNext;
    coordVec_t floorsY, gapsPos, gapsWidth;
    coordVec_t floorsNxt, gapsPosNxt, gapsWidthNxt;
    wide_t     bottom, yFall;
    logic [15:0] lfsr;
    logic      unusedLfsr;

    fdown_lfsr #(.SEED(LFSR_SEED)) uLfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign unusedLfsr = ^{lfsr[15:13], lfsr[9]};

    function automatic logic floorCatches(input coord_t f, input coord_t gp, input coord_t gw,
                                          input wide_t xw, input wide_t bot);
        logic overGap;
        overGap = (xw - R_W >= {1'b0, gp}) && (xw + R_W < {1'b0, gp} + {1'b0, gw});
        return (bot - SCROLL_W <= {1'b0, f}) && ({1'b0, f} <= bot + GRAV_W) && !overGap;
    endfunction

    // Wrapped floors all share the LFSR sample of this cycle.
    always_comb begin
        floorsNxt    = floorsY;
        gapsPosNxt   = gapsPos;
        gapsWidthNxt = gapsWidth;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ({1'b0, floorsY[i]} <= SCROLL_W) begin
                floorsNxt[i]    = coord_t'(SCREEN_H - 1);
                gapsPosNxt[i]   = {1'b0, lfsr[8:0]};
                gapsWidthNxt[i] = coord_t'(MIN_GAP_W) + coord_t'({lfsr[12:10], 2'b00});
            end else begin
                floorsNxt[i] = floorsY[i] - coord_t'(SCROLL);
            end
        end
    end

    always_comb begin
        xNext = xPos;
        if (btn_left && !btn_right)
            xNext = ({1'b0, xPos} < R_W + XS_W) ? coord_t'(BALL_R) : xPos - coord_t'(XSPEED);
        else if (btn_right && !btn_left)
            xNext = ({1'b0, xPos} + XS_W > X_MAX) ? coord_t'(X_MAX) : xPos + coord_t'(XSPEED);
    end

    // Walk floors from last to first so floor 0 wins when several catch.
    always_comb begin
        bottom = {1'b0, yPos} + R_W;
        yFall  = {1'b0, yPos} + GRAV_W;
        if (yFall > Y_MAX)
            yFall = Y_MAX;
        yNext = yFall[COORD_W-1:0];
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (floorCatches(floorsY[i], gapsPos[i], gapsWidth[i], {1'b0, xPos}, bottom))
                yNext = floorsY[i] - coord_t'(BALL_R);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = PLAY;
            PLAY:    if (frame_tick) stateNxt = FLOORS;
            FLOORS:  stateNxt = BALL_X;
            BALL_X:  stateNxt = BALL_Y;
            BALL_Y:  stateNxt = ({1'b0, yNext} <= R_W) ? OVER : PLAY;
            OVER:    if (start) stateNxt = PLAY;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == OVER && start)) begin
            xPos      <= X_RST;
            yPos      <= Y_RST;
            floorsY   <= FLOORS_RST;
            gapsPos   <= GAPS_RST;
            gapsWidth <= WIDTHS_RST;
        end else begin
            case (state)
                FLOORS: begin
                    floorsY   <= floorsNxt;
                    gapsPos   <= gapsPosNxt;
                    gapsWidth <= gapsWidthNxt;
                end
                BALL_X:  xPos <= xNext;
                BALL_Y:  yPos <= yNext;
                default: ;
            endcase
        end
    end

    assign x_pos      = xPos;
    assign y_pos      = yPos;
    assign floors_y   = packBus(floorsY);
    assign gaps_pos   = packBus(gapsPos);
    assign gaps_width = packBus(gapsWidth);
    assign game_over  = (state == OVER);
    assign busy       = (state == FLOORS) || (state == BALL_X) || (state == BALL_Y);

endmodule

// File: doc/fdown_physics.md
Name: fdown_physics

Overview:
Per-frame game-state update engine for the falling-ball game. It sits directly upstream of the ball and floor draw stages. It replaces the static ball, floor and gap registers in the top level with live state that advances once per VGA frame. It applies left/right motion, gravity, floor scrolling, landing and gap fall-through, floor recycling with pseudo-random gaps, and game-over detection.

Parameters:
BALL_R, 8, ball half-size in px; the ball spans x±BALL_R and y±BALL_R
GRAVITY, 4, px fallen per frame when unsupported
SCROLL, 1, px all floors rise per frame
XSPEED, 3, px moved horizontally per frame per button
SCREEN_W, 640, active width in px
SCREEN_H, 480, active height in px
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock (same domain as the frame pulse)
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame, from the VGA frame output
start  in  1  level; begins or restarts a game
btn_left  in  1  level; move ball left
btn_right  in  1  level; move ball right
x_pos  out  10  ball centre x
y_pos  out  10  ball centre y
floors_y  out  30  three 10-bit floor y values; floor i occupies bits [10i+9:10i]
gaps_pos  out  30  three 10-bit gap left edges, packed the same way
gaps_width  out  30  three 10-bit gap widths, packed the same way
game_over  out  1  high while in the OVER state
busy  out  1  high during the update states (FLOORS, BALL_X, BALL_Y)

Behaviour:
- The single clock is clk. Reset is synchronous and active-high on rst. Reset is sampled on every edge and overrides all other activity, including an update in progress.
- Reset values:
  - x_pos=320, y_pos=240
  - floors_y={100,250,400}, gaps_pos={200,300,150}, gaps_width={40,35,60}
  - game_over=0, busy=0, LFSR=LFSR_SEED, state=IDLE
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clock in every state so that gap values depend on player timing.
- States:
  - IDLE: all outputs hold. start=1 -> PLAY.
  - PLAY: frame_tick=1 -> FLOORS. All other inputs are ignored.
  - FLOORS (1 cycle): for each floor i:
    - if floors_y[i] <= SCROLL: floors_y[i]=SCREEN_H-1; gaps_pos[i]={1'b0,lfsr[8:0]}; gaps_width[i]=40+4*lfsr[12:10] (range 40..68).
    - otherwise floors_y[i] -= SCROLL.
    - If two floors wrap in the same cycle, both take the same LFSR sample.
  - BALL_X (1 cycle):
    - left only: x -= XSPEED. Right only: x += XSPEED. Both or neither: x unchanged.
    - Clamp x to [BALL_R, SCREEN_W-1-BALL_R].
  - BALL_Y (1 cycle), using the updated floor and x values:
    - bottom = y_pos + BALL_R.
    - Floor i catches the ball when bottom-SCROLL <= floors_y[i] <= bottom+GRAVITY, and the ball is not over gap i.
    - Over gap i means x-BALL_R >= gaps_pos[i] and x+BALL_R < gaps_pos[i]+gaps_width[i].
    - Caught: y = floors_y[i]-BALL_R. Priority when several floors catch: floor 0 > floor 1 > floor 2.
    - Not caught: y += GRAVITY, clamped to SCREEN_H-1-BALL_R.
    - If the new y <= BALL_R -> OVER; otherwise -> PLAY.
  - OVER: game_over=1 and positions are frozen. start=1 -> all positions return to their reset values (LFSR is not reset) -> PLAY.
- Latency: all outputs are final 3 cycles after frame_tick. busy is high for exactly those 3 cycles.
- frame_tick arriving while busy is ignored (it is not queued).
- All comparisons use 11-bit unsigned arithmetic so there is no wrap-around on add or subtract.

Decomposition:
- Shared package fdown_pkg holds:
  - constants: SCREEN_W, SCREEN_H, NUM_FLOORS=3, COORD_W=10
  - reset tables for floors, gaps and widths
  - state enum: IDLE, PLAY, FLOORS, BALL_X, BALL_Y, OVER
  - pack/unpack helpers for the 30-bit buses
- One natural sub-module, fdown_lfsr (16-bit LFSR with seed and reset).

Test Plan:
- rst=1 for 1 cycle, then start -> reset values on every output; after one tick with no buttons, at tick+3: y_pos=244 and floors_y={99,249,399}.
- btn_left held through ticks with x=320 -> x=317, then 314. Hold until x=8, then one more tick -> x stays 8. Both buttons held -> x unchanged.
- Floor 2 at y=1 on a tick -> floors_y[29:20]=479; gap and width match the LFSR sample captured in FLOORS; width is in 40..68.
- Ball bottom equal to floor 0 (y=392, x=320, gap 150..210) -> after the tick y=391 (riding the floor). Move x into the gap -> y increases by 4 per frame until caught by a lower floor or the bottom clamp (471).
- Ball riding a floor at y=10 with SCROLL=1 -> reaches y<=8 -> game_over=1 within 3 cycles; further ticks do not move the ball; start -> reset values, PLAY.
- rst asserted during BALL_X -> next cycle all reset values, busy=0, state IDLE.
